// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: decodes funct3 against the comparator flags and registers a one-cycle redirect/flush on
// mispredict. It also keeps a 2-bit BHT for fetch and saturating branch/mispredict counters.
module branch_resolver #(
  parameter int XLEN      = 32,
  parameter int BHT_IDX_W = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_funct3,
  input  logic [XLEN-1:0]  br_pc,
  input  logic [XLEN-1:0]  br_imm,
  input  logic             br_pred_taken,
  output logic             BrUn,
  input  logic             BrLT,
  input  logic             BrEq,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  output logic             br_illegal,
  input  logic [XLEN-1:0]  lookup_pc,
  output logic             lookup_taken,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int BHT_N = 1 << BHT_IDX_W;

  logic             redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic             br_illegal_q, br_illegal_d;
  logic [CNT_W-1:0] branch_count_q, branch_count_d;
  logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;
  logic [1:0]       bht_q [BHT_N];
  logic [1:0]       bht_d [BHT_N];

  logic                 accept;
  logic                 legal;
  logic                 taken;
  logic                 mispredict;
  logic [XLEN-1:0]      target;
  logic [XLEN-1:0]      fallthrough;
  logic [BHT_IDX_W-1:0] upd_idx;
  logic [BHT_IDX_W-1:0] lk_idx;
  logic [1:0]           upd_ctr;
  logic                 unused_lookup_bits;

  // Handshake: a branch is consumed on any posedge where br_valid && br_ready; the source must hold br_valid and its
  // operands stable until then. br_ready drops only for the single bubble cycle in which a redirect is being presented.
  assign br_ready = !redirect_valid_q;
  assign accept   = br_valid && br_ready;

  assign BrUn    = br_funct3[1];
  assign upd_idx = br_pc[BHT_IDX_W+1:2];
  assign lk_idx  = lookup_pc[BHT_IDX_W+1:2];
  assign upd_ctr = bht_q[upd_idx];

  // Prediction reads the registered table, so a same-index update this cycle is not visible until the next one.
  assign lookup_taken       = bht_q[lk_idx][1];
  assign unused_lookup_bits = ^{lookup_pc[XLEN-1:BHT_IDX_W+2], lookup_pc[1:0]};

  always_comb begin
    taken = 1'b0;
    legal = 1'b1;
    case (br_funct3)
      3'b000:  taken = BrEq;
      3'b001:  taken = !BrEq;
      3'b100:  taken = BrLT;
      3'b101:  taken = !BrLT;
      3'b110:  taken = BrLT;
      3'b111:  taken = !BrLT;
      default: legal = 1'b0;
    endcase
    mispredict  = taken != br_pred_taken;
    target      = br_pc + br_imm;
    fallthrough = br_pc + XLEN'(4);
  end

  always_comb begin
    redirect_valid_d   = 1'b0;
    redirect_pc_d      = redirect_pc_q;
    br_illegal_d       = 1'b0;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    for (int i = 0; i < BHT_N; i++) begin
      bht_d[i] = bht_q[i];
    end
    if (accept) begin
      if (legal) begin
        if (branch_count_q != '1) begin
          branch_count_d = branch_count_q + CNT_W'(1);
        end
        if (mispredict) begin
          redirect_valid_d = 1'b1;
          redirect_pc_d    = taken ? target : fallthrough;
          if (mispredict_count_q != '1) begin
            mispredict_count_d = mispredict_count_q + CNT_W'(1);
          end
        end
        if (taken) begin
          if (upd_ctr != 2'b11) bht_d[upd_idx] = upd_ctr + 2'b01;
        end else begin
          if (upd_ctr != 2'b00) bht_d[upd_idx] = upd_ctr - 2'b01;
        end
      end else begin
        br_illegal_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_valid_q   <= 1'b0;
      redirect_pc_q      <= '0;
      br_illegal_q       <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
      for (int i = 0; i < BHT_N; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else begin
      redirect_valid_q   <= redirect_valid_d;
      redirect_pc_q      <= redirect_pc_d;
      br_illegal_q       <= br_illegal_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
      for (int i = 0; i < BHT_N; i++) begin
        bht_q[i] <= bht_d[i];
      end
    end
  end

  assign redirect_valid   = redirect_valid_q;
  assign flush            = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign br_illegal       = br_illegal_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: the driver pushes each expected redirect/illegal event and a negedge monitor pops
// and compares it. Counters, BHT predictions, BrUn and br_ready are checked directly against hand-computed values.
module tb_branch_resolver;

  localparam int XLEN = 32;
  localparam int CNT_W = 32;
  localparam int W = XLEN + 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             br_valid = 1'b0;
  logic             br_ready;
  logic [2:0]       br_funct3 = '0;
  logic [XLEN-1:0]  br_pc = '0;
  logic [XLEN-1:0]  br_imm = '0;
  logic             br_pred_taken = 1'b0;
  logic             BrUn;
  logic             BrLT = 1'b0;
  logic             BrEq = 1'b0;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             flush;
  logic             br_illegal;
  logic [XLEN-1:0]  lookup_pc = '0;
  logic             lookup_taken;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got;

  branch_resolver #(.XLEN(XLEN), .BHT_IDX_W(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .br_valid(br_valid), .br_ready(br_ready), .br_funct3(br_funct3), .br_pc(br_pc), .br_imm(br_imm),
    .br_pred_taken(br_pred_taken), .BrUn(BrUn), .BrLT(BrLT), .BrEq(BrEq),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush), .br_illegal(br_illegal),
    .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every event the DUT presents must match the oldest expected one.
  always @(negedge clk) begin
    if (redirect_valid || flush || br_illegal) begin
      check("flush_eq_redirect", 64'(flush), 64'(redirect_valid));
      got = {br_illegal, redirect_valid, redirect_valid ? redirect_pc : {XLEN{1'b0}}};
      if (exp_q.size() == 0) check("unexpected_event", 64'(got), 64'(0));
      else check("redirect_event", 64'(got), 64'(exp_q.pop_front()));
    end
  end

  // Driver. kind: 0 = no event expected, 1 = redirect to exp_pc, 2 = illegal pulse.
  task automatic issue(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                       input logic pred, input logic lt, input logic eq, input int kind,
                       input logic [31:0] exp_pc, output int waited, output logic [31:0] bc,
                       output logic lk, output logic brun);
    waited = 0;
    @(negedge clk);
    while (!br_ready && waited < 8) begin
      waited++;
      @(negedge clk);
    end
    if (!br_ready) check("ready_timeout", 64'(br_ready), 64'(1));
    br_funct3 = f3; br_pc = pc; br_imm = imm; br_pred_taken = pred;
    BrLT = lt; BrEq = eq; lookup_pc = pc; br_valid = 1'b1;
    if (kind == 1) exp_q.push_back({2'b01, exp_pc});
    if (kind == 2) exp_q.push_back({2'b10, 32'h0});
    #1;
    bc = branch_count; lk = lookup_taken; brun = BrUn;
    @(posedge clk);
    #1 br_valid = 1'b0;
  endtask

  task automatic br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                    input logic pred, input logic lt, input logic eq, input int kind, input logic [31:0] exp_pc);
    int w;
    logic [31:0] b;
    logic l, u;
    issue(f3, pc, imm, pred, lt, eq, kind, exp_pc, w, b, l, u);
  endtask

  task automatic lk_check(input string name, input logic [31:0] pc, input logic exp);
    lookup_pc = pc;
    #1;
    check(name, 64'(lookup_taken), 64'(exp));
  endtask

  task automatic cnt_check(input string name, input int bc, input int mc);
    check({name, "_branch_count"}, 64'(branch_count), 64'(bc));
    check({name, "_mispredict_count"}, 64'(mispredict_count), 64'(mc));
  endtask

  logic [2:0]  b2b_f3   [4] = '{3'b000, 3'b000, 3'b001, 3'b110};
  logic [31:0] b2b_pc   [4] = '{32'h104, 32'h108, 32'h10C, 32'h110};
  logic        b2b_pred [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic        b2b_eq   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic        b2b_old  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int w;
    logic [31:0] b;
    logic l, u;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_redirect_valid", 64'(redirect_valid), 64'(0));
    check("reset_flush", 64'(flush), 64'(0));
    check("reset_illegal", 64'(br_illegal), 64'(0));
    check("reset_redirect_pc", 64'(redirect_pc), 64'(0));
    check("reset_ready", 64'(br_ready), 64'(1));
    cnt_check("reset", 0, 0);
    lk_check("reset_lookup_100", 32'h100, 1'b0);

    // Taken BEQ predicted not-taken, then a held branch during the bubble that must be ignored.
    br(3'b000, 32'h100, 32'h20, 1'b0, 1'b0, 1'b1, 1, 32'h120);
    @(negedge clk);
    check("bubble_ready_low", 64'(br_ready), 64'(0));
    cnt_check("beq_miss", 1, 1);
    lk_check("bht_100_after_1", 32'h100, 1'b1);
    br_funct3 = 3'b010; br_valid = 1'b1;
    @(posedge clk);
    #1 br_valid = 1'b0;
    @(negedge clk);
    check("ready_after_bubble", 64'(br_ready), 64'(1));
    cnt_check("ignored", 1, 1);

    // Counter saturation at 11 then walk back down.
    br(3'b000, 32'h100, 32'h20, 1'b1, 1'b0, 1'b1, 0, 32'h0);
    br(3'b000, 32'h100, 32'h20, 1'b1, 1'b0, 1'b1, 0, 32'h0);
    @(negedge clk);
    cnt_check("beq_hits", 3, 1);
    lk_check("bht_100_sat", 32'h100, 1'b1);
    br(3'b000, 32'h100, 32'h20, 1'b1, 1'b0, 1'b0, 1, 32'h104);
    @(negedge clk);
    cnt_check("beq_nt_miss", 4, 2);
    lk_check("bht_100_down1", 32'h100, 1'b1);
    br(3'b000, 32'h100, 32'h20, 1'b0, 1'b0, 1'b0, 0, 32'h0);
    @(negedge clk);
    cnt_check("beq_nt_hit", 5, 2);
    lk_check("bht_100_down2", 32'h100, 1'b0);

    // BrUn select and signed/unsigned decodes.
    issue(3'b110, 32'h204, 32'h40, 1'b1, 1'b1, 1'b0, 0, 32'h0, w, b, l, u);
    check("brun_bltu", 64'(u), 64'(1));
    issue(3'b101, 32'h208, 32'h40, 1'b1, 1'b0, 1'b0, 0, 32'h0, w, b, l, u);
    check("brun_bge", 64'(u), 64'(0));
    @(negedge clk);
    cnt_check("bltu_bge", 7, 2);
    lk_check("bht_204", 32'h204, 1'b1);
    lk_check("bht_208", 32'h208, 1'b1);
    br(3'b101, 32'h30C, 32'h100, 1'b1, 1'b1, 1'b0, 1, 32'h310);
    br(3'b100, 32'h400, 32'hFFFF_FFF0, 1'b0, 1'b1, 1'b0, 1, 32'h3F0);

    // Address wrap on target and fallthrough, then BGEU.
    br(3'b001, 32'hFFFF_FFF8, 32'h10, 1'b0, 1'b0, 1'b0, 1, 32'h0000_0008);
    br(3'b001, 32'hFFFF_FFFC, 32'h10, 1'b1, 1'b0, 1'b1, 1, 32'h0000_0000);
    br(3'b111, 32'h500, 32'h8, 1'b0, 1'b0, 1'b0, 1, 32'h508);
    @(negedge clk);
    cnt_check("wrap_group", 12, 7);
    lk_check("bht_fff8", 32'hFFFF_FFF8, 1'b1);
    lk_check("bht_fffc", 32'hFFFF_FFFC, 1'b0);

    // Reserved funct3 values: illegal pulse only.
    br(3'b010, 32'h104, 32'h40, 1'b1, 1'b1, 1'b1, 2, 32'h0);
    br(3'b011, 32'h104, 32'h40, 1'b1, 1'b1, 1'b1, 2, 32'h0);
    @(negedge clk);
    cnt_check("illegal", 12, 7);
    lk_check("bht_104_untouched", 32'h104, 1'b1);

    // Back-to-back correctly predicted branches with same-index lookup during each update.
    for (int i = 0; i < 4; i++) begin
      issue(b2b_f3[i], b2b_pc[i], 32'h40, b2b_pred[i], 1'b0, b2b_eq[i], 0, 32'h0, w, b, l, u);
      check("b2b_ready", 64'(w), 64'(0));
      check("b2b_count", 64'(b), 64'(12 + i));
      check("rbw_lookup", 64'(l), 64'(b2b_old[i]));
    end
    @(negedge clk);
    cnt_check("b2b", 16, 7);
    lk_check("bht_104_after", 32'h104, 1'b0);
    lk_check("bht_108_after", 32'h108, 1'b1);
    lk_check("bht_110_after", 32'h110, 1'b0);

    // Reset coinciding with a mispredicting accept drops the redirect.
    reset = 1'b1;
    br(3'b000, 32'h108, 32'h20, 1'b0, 1'b0, 1'b1, 0, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("reset_drops_redirect", 64'(redirect_valid), 64'(0));
    check("reset_clears_pc", 64'(redirect_pc), 64'(0));
    cnt_check("post_reset", 0, 0);
    lk_check("bht_108_reset", 32'h108, 1'b0);
    lk_check("bht_100_reset", 32'h100, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Execute-stage consumer of the branch comparator's flags (BrLT/BrEq).
- Drives BrUn to the comparator, decodes funct3 into a taken/not-taken decision, and computes the branch target.
- Registers a one-cycle redirect/flush toward fetch on misprediction.
- Owns a 2-bit-counter branch history table (BHT) used by fetch for prediction, plus saturating branch/mispredict statistics counters.

Parameters:
- XLEN, 32, datapath/PC width
- BHT_IDX_W, 4, log2 of BHT entries (16 entries, indexed by pc[BHT_IDX_W+1:2])
- CNT_W, 32, width of statistics counters

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- br_valid  in  1  branch instruction presented this cycle
- br_ready  out  1  resolver can accept a branch
- br_funct3  in  3  RV32I B-type funct3
- br_pc  in  XLEN  PC of the branch
- br_imm  in  XLEN  sign-extended B-immediate
- br_pred_taken  in  1  prediction fetch used for this branch
- BrUn  out  1  unsigned-compare select to comparator
- BrLT  in  1  comparator less-than flag
- BrEq  in  1  comparator equal flag
- redirect_valid  out  1  registered pulse: fetch must redirect
- redirect_pc  out  XLEN  corrected next PC
- flush  out  1  registered pulse: kill younger instructions (equals redirect_valid)
- br_illegal  out  1  registered pulse: reserved funct3 accepted
- lookup_pc  in  XLEN  fetch PC for prediction
- lookup_taken  out  1  combinational prediction (MSB of indexed counter)
- branch_count  out  CNT_W  resolved legal branches, saturating
- mispredict_count  out  CNT_W  mispredictions, saturating

Behaviour:
- Reset (synchronous, reset=1 at posedge):
  - redirect_valid=0, flush=0, br_illegal=0, redirect_pc=0.
  - branch_count=0, mispredict_count=0.
  - All BHT entries = 2'b01 (weakly not-taken).
  - Reset wins over any simultaneous accept; an in-flight redirect is dropped.
- BrUn (combinational) = br_funct3[1]. Valid for 110/111; don't-care-safe for the others.
- Accept: br_valid && br_ready at posedge. br_ready = !redirect_valid, so there is exactly one bubble cycle after a redirect. Non-redirecting branches may be accepted back-to-back every cycle.
- Decision (combinational, from the same-cycle BrLT/BrEq):
  - 000 BEQ: taken=BrEq
  - 001 BNE: taken=!BrEq
  - 100 BLT: taken=BrLT
  - 101 BGE: taken=!BrLT
  - 110 BLTU: taken=BrLT
  - 111 BGEU: taken=!BrLT
  - 010/011: illegal; taken=0.
- Arithmetic: target = br_pc + br_imm mod 2^XLEN (wrap, no overflow flag); fallthrough = br_pc + 4 mod 2^XLEN.
- Legal branch accepted (registered, visible the next cycle):
  - If taken != br_pred_taken: redirect_valid=flush=1 for exactly one cycle, and redirect_pc = taken ? target : fallthrough; mispredict_count increments (saturates at all-ones).
  - Otherwise redirect_valid=0 and redirect_pc holds its previous value.
  - branch_count increments (saturates).
  - BHT[br_pc index] updates: taken → +1, saturating at 11; not-taken → -1, saturating at 00.
- Illegal funct3 accepted: br_illegal=1 for one cycle. No redirect, no counter change, no BHT update.
- BHT read/write collision: when lookup_pc and br_pc share an index in the cycle of an update, lookup_taken returns the pre-update value (read-before-write).
- br_valid while br_ready=0: ignored entirely; upstream must hold it.
- Latency: decision to redirect_valid is 1 cycle.
- Outputs change only on clock edges, except BrUn and lookup_taken.

Test Plan:
- Reset, then lookup_pc=0x100 → lookup_taken=0; all counters 0; redirect_valid=0; issue reset mid-redirect cycle → redirect_valid=0 next cycle.
- BEQ pc=0x100, imm=0x20, BrEq=1, pred=0 → next cycle redirect_valid=flush=1, redirect_pc=0x120, mispredict_count=1, br_ready=0 for that cycle; same branch again → BHT entry reaches 11, lookup_taken(0x100)=1.
- BLTU funct3=110 → BrUn=1; BGE funct3=101 → BrUn=0; BGE with BrLT=0, pred=1 → no redirect, branch_count increments.
- BNE pc=0xFFFFFFF8, imm=0x10, BrEq=0, pred=0 → redirect_pc=0x00000008 (wrap); not-taken mispredict pc=0xFFFFFFFC → redirect_pc=0x00000000.
- funct3=010 with br_valid → br_illegal pulse, branch_count and BHT unchanged, no redirect.
- Back-to-back correctly predicted branches every cycle → br_ready stays 1, branch_count +1 per cycle; same-index lookup during update returns old counter MSB.
